// File: rtl/serial_to_parallel_demux_pkg.sv
// Shared types and defaults for the serial-to-parallel demux slice.
// Imported by the top and the bit counter so both agree on widths.
package s2p_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_MSB_FIRST = 1;

  typedef enum logic {
    MSB_FIRST_E,
    LSB_FIRST_E
  } bitOrder_e;

  // Counter width for a word of the given length; index range is 0..width-1.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_to_parallel_demux_bit_counter.sv
// Mod-WIDTH bit position counter; o_last flags the slot that completes a word.
// Advances only on an accepted bit, so serial gaps freeze it.
module s2p_bit_counter
  import s2p_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_last
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] r_cnt;

  assign o_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (o_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_to_parallel_demux.sv
// Steers a serial bit stream into WIDTH-bit words and offers each completed
// word on a valid/ready port, with a one-word output register.
module serial_to_parallel_demux
  import s2p_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = DEFAULT_MSB_FIRST
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_serial_valid,
  input  logic             i_serial_data,
  output logic             o_serial_ready,
  output logic             o_parallel_valid,
  output logic [WIDTH-1:0] o_parallel_data,
  input  logic             i_parallel_ready
);

  localparam bitOrder_e ORDER = (MSB_FIRST != 0) ? MSB_FIRST_E : LSB_FIRST_E;

  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_outQ;
  logic             r_outFull;
  logic [WIDTH-1:0] w_shNext;
  logic             w_last;
  logic             w_accept;
  logic             w_take;

  s2p_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bitCounter (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_accept),
    .o_last(w_last)
  );

  // Stall only the word-completing bit while the previous word is still unread.
  assign o_serial_ready   = !(w_last && r_outFull && !i_parallel_ready);
  assign w_accept         = i_serial_valid && o_serial_ready;
  assign w_take           = r_outFull && i_parallel_ready;
  assign o_parallel_valid = r_outFull;
  assign o_parallel_data  = r_outQ;

  always_comb begin
    w_shNext = r_sh;
    if (ORDER == MSB_FIRST_E) begin
      w_shNext = {r_sh[WIDTH-2:0], i_serial_data};
    end else begin
      w_shNext = {i_serial_data, r_sh[WIDTH-1:1]};
    end
  end

  // A simultaneous take and completion reloads the register with no bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh      <= '0;
      r_outQ    <= '0;
      r_outFull <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sh <= w_shNext;
      end
      if (w_accept && w_last) begin
        r_outQ    <= w_shNext;
        r_outFull <= 1'b1;
      end else if (w_take) begin
        r_outFull <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_demux.sv
// Directed bench: an MSB-first and an LSB-first instance share one stimulus
// stream; expected words are queued when sent and popped when taken.
module tb_serial_to_parallel_demux;

  logic       clk = 1'b0;
  logic       rst;
  logic       sValid;
  logic       sData;
  logic       pReady;
  logic       rdyM, pvM, rdyL, pvL;
  logic [7:0] pdM, pdL;

  int         errors = 0;
  int         checks = 0;
  int         cycle = 0;
  int         stalls = 0;
  logic [7:0] qM[$];
  logic [7:0] qL[$];
  int         takeTimes[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  serial_to_parallel_demux #(.WIDTH(8), .MSB_FIRST(1)) dutM (
    .i_clk(clk), .i_rst(rst), .i_serial_valid(sValid), .i_serial_data(sData),
    .o_serial_ready(rdyM), .o_parallel_valid(pvM), .o_parallel_data(pdM),
    .i_parallel_ready(pReady)
  );

  serial_to_parallel_demux #(.WIDTH(8), .MSB_FIRST(0)) dutL (
    .i_clk(clk), .i_rst(rst), .i_serial_valid(sValid), .i_serial_data(sData),
    .o_serial_ready(rdyL), .o_parallel_valid(pvL), .o_parallel_data(pdL),
    .i_parallel_ready(pReady)
  );

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit is held until accepted; each refused cycle counts as a stall.
  task automatic applyStimulus(input logic b);
    logic acc;
    int   n;
    sValid = 1'b1;
    sData  = b;
    acc    = 1'b0;
    n      = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = rdyM;
      if (!acc) stalls++;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) checkOutput("serial accept timeout", 32'(rdyM), 32'd1);
  endtask

  task automatic sendWord(input logic [7:0] w);
    qM.push_back(w);
    qL.push_back(rev8(w));
    for (int i = 7; i >= 0; i--) applyStimulus(w[i]);
  endtask

  task automatic idle(input int n);
    sValid = 1'b0;
    for (int i = 0; i < n; i++) begin
      sData = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pvM && pReady) begin
        if (qM.size() == 0) begin
          checkOutput("M spurious valid", 32'(pvM), 32'd0);
        end else begin
          checkOutput("M word", 32'(pdM), 32'(qM.pop_front()));
          takeTimes.push_back(cycle);
        end
      end
      if (pvL && pReady) begin
        if (qL.size() == 0) begin
          checkOutput("L spurious valid", 32'(pvL), 32'd0);
        end else begin
          checkOutput("L word", 32'(pdL), 32'(qL.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] w;
    int         bitIdx;
    rst    = 1'b1;
    sValid = 1'b0;
    sData  = 1'b0;
    pReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset pvalid", 32'(pvM), 32'd0);
    checkOutput("reset pdata", 32'(pdM), 32'd0);
    checkOutput("reset cnt", 32'(dutM.u_bitCounter.r_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ready after reset", 32'(rdyM), 32'd1);

    $display("[TB] test 1: MSB-first A5");
    sendWord(8'hA5);
    checkOutput("t1 valid latency", 32'(pvM), 32'd1);
    checkOutput("t1 data M", 32'(pdM), 32'hA5);
    idle(1);
    checkOutput("t1 single pulse", 32'(pvM), 32'd0);

    $display("[TB] test 2: LSB-first A5 then F0");
    checkOutput("t2 data L A5", 32'(pdL), 32'hA5);
    sendWord(8'h0F);
    checkOutput("t2 valid L", 32'(pvL), 32'd1);
    checkOutput("t2 data L F0", 32'(pdL), 32'hF0);
    idle(2);

    $display("[TB] test 3: backpressure");
    pReady = 1'b0;
    sendWord(8'h3C);
    checkOutput("t3 held valid", 32'(pvM), 32'd1);
    w = 8'hC3;
    qM.push_back(w);
    qL.push_back(rev8(w));
    for (int i = 7; i >= 1; i--) applyStimulus(w[i]);
    sValid = 1'b1;
    sData  = w[0];
    @(negedge clk);
    checkOutput("t3 stall ready", 32'(rdyM), 32'd0);
    checkOutput("t3 held data", 32'(pdM), 32'h3C);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("t3 still stalled", 32'(rdyM), 32'd0);
    checkOutput("t3 still held", 32'(pdM), 32'h3C);
    @(posedge clk);
    #1;
    pReady = 1'b1;
    @(negedge clk);
    checkOutput("t3 ready on take", 32'(rdyM), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("t3 reload valid", 32'(pvM), 32'd1);
    checkOutput("t3 reload data", 32'(pdM), 32'hC3);
    idle(1);
    checkOutput("t3 drained", 32'(pvM), 32'd0);

    $display("[TB] test 4: streaming");
    takeTimes.delete();
    stalls = 0;
    sendWord(8'h01);
    sendWord(8'h80);
    sendWord(8'hFF);
    idle(2);
    checkOutput("t4 stalls", 32'(stalls), 32'd0);
    checkOutput("t4 word count", 32'(takeTimes.size()), 32'd3);
    if (takeTimes.size() == 3) begin
      checkOutput("t4 spacing 1", 32'(takeTimes[1] - takeTimes[0]), 32'd8);
      checkOutput("t4 spacing 2", 32'(takeTimes[2] - takeTimes[1]), 32'd8);
    end

    $display("[TB] test 5: random gaps");
    w = 8'h5A;
    qM.push_back(w);
    qL.push_back(rev8(w));
    bitIdx = 0;
    for (int i = 7; i >= 0; i--) begin
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
      checkOutput("t5 cnt frozen", 32'(dutM.u_bitCounter.r_cnt), 32'(bitIdx));
      applyStimulus(w[i]);
      bitIdx++;
    end
    checkOutput("t5 data", 32'(pdM), 32'h5A);
    idle(2);

    $display("[TB] test 6: reset mid-word");
    pReady = 1'b0;
    sendWord(8'h11);
    checkOutput("t6 held before reset", 32'(pdM), 32'h11);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    sValid = 1'b0;
    checkOutput("t6 partial cnt", 32'(dutM.u_bitCounter.r_cnt), 32'd5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("t6 reset pvalid", 32'(pvM), 32'd0);
    checkOutput("t6 reset pdata M", 32'(pdM), 32'd0);
    checkOutput("t6 reset pdata L", 32'(pdL), 32'd0);
    checkOutput("t6 reset cnt", 32'(dutM.u_bitCounter.r_cnt), 32'd0);
    qM.delete();
    qL.delete();
    pReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6 ready after reset", 32'(rdyM), 32'd1);
    sendWord(8'hE7);
    checkOutput("t6 data", 32'(pdM), 32'hE7);
    idle(3);

    checkOutput("queue M drained", 32'(qM.size()), 32'd0);
    checkOutput("queue L drained", 32'(qL.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
